// File: rtl/guard_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// guard_recovery_ctrl: isolate, reset, settle and re-enable a guarded subordinate
// Revision: 1.0
// ============================================================================
module guard_recovery_ctrl #(
   parameter int IsoTimeout    = 1024,
   parameter int RstHoldCycles = 16,
   parameter int SettleCycles  = 8,
   parameter int MaxRecov      = 3,
   parameter int TmrWidth      = $clog2(((IsoTimeout > RstHoldCycles) ?
                                   ((IsoTimeout > SettleCycles) ? IsoTimeout : SettleCycles) :
                                   ((RstHoldCycles > SettleCycles) ? RstHoldCycles : SettleCycles)) + 1)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       enable_i,
   input  logic       rst_req_i,
   input  logic       isolated_i,
   input  logic       sw_clear_i,
   output logic       isolate_o,
   output logic       sub_rst_no,
   output logic       guard_ena_o,
   output logic       irq_clr_o,
   output logic       busy_o,
   output logic       forced_o,
   output logic       fail_o,
   output logic [7:0] recov_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISOLATE = 3'd1,
      S_RESET   = 3'd2,
      S_SETTLE  = 3'd3,
      S_RESUME  = 3'd4,
      S_FAILED  = 3'd5
   } state_e;

   localparam logic [TmrWidth-1:0] c_ISO_LAST = TmrWidth'(IsoTimeout - 1);
   localparam logic [TmrWidth-1:0] c_RST_LAST = TmrWidth'(RstHoldCycles - 1);
   localparam logic [TmrWidth-1:0] c_SET_LAST = TmrWidth'(SettleCycles - 1);

   state_e              state_q, state_d;
   logic [TmrWidth-1:0] timer_q, timer_d;
   logic                forced_q, forced_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          cnt_inc;
   logic                isolate_q, isolate_d;
   logic                sub_rst_nq, sub_rst_nd;
   logic                guard_ena_q, guard_ena_d;
   logic                irq_clr_q, irq_clr_d;
   logic                busy_q, busy_d;
   logic                fail_q, fail_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         forced_q    <= 1'b0;
         cnt_q       <= 8'd0;
         isolate_q   <= 1'b0;
         sub_rst_nq  <= 1'b1;
         guard_ena_q <= 1'b1;
         irq_clr_q   <= 1'b0;
         busy_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         forced_q    <= forced_d;
         cnt_q       <= cnt_d;
         isolate_q   <= isolate_d;
         sub_rst_nq  <= sub_rst_nd;
         guard_ena_q <= guard_ena_d;
         irq_clr_q   <= irq_clr_d;
         busy_q      <= busy_d;
         fail_q      <= fail_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      forced_d = forced_q;
      cnt_d    = cnt_q;
      cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      if (sw_clear_i) cnt_d = 8'd0;

      case (state_q)
         S_IDLE: begin
            if (enable_i && rst_req_i) begin
               state_d  = S_ISOLATE;
               timer_d  = '0;
               forced_d = 1'b0;
            end
         end
         S_ISOLATE: begin
            // A clean isolation wins over a simultaneous timeout.
            if (isolated_i) begin
               state_d = S_RESET;
               timer_d = '0;
            end else if (timer_q == c_ISO_LAST) begin
               state_d  = S_RESET;
               timer_d  = '0;
               forced_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RESET: begin
            if (timer_q == c_RST_LAST) begin
               state_d = S_SETTLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (timer_q == c_SET_LAST) begin
               if (!sw_clear_i) cnt_d = cnt_inc;
               state_d = (32'(cnt_inc) >= MaxRecov) ? S_FAILED : S_RESUME;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RESUME: begin
            if (!isolated_i) state_d = S_IDLE;
         end
         S_FAILED: begin
            if (sw_clear_i) state_d = S_RESUME;
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase

      // Outputs are a registered decode of the upcoming state.
      isolate_d   = (state_d == S_ISOLATE) || (state_d == S_RESET) ||
                    (state_d == S_SETTLE)  || (state_d == S_FAILED);
      sub_rst_nd  = (state_d != S_RESET);
      guard_ena_d = (state_d != S_RESET) && (state_d != S_SETTLE);
      irq_clr_d   = (state_d == S_SETTLE) && (timer_d == c_SET_LAST);
      busy_d      = (state_d != S_IDLE);
      fail_d      = (state_d == S_FAILED);
   end

   assign isolate_o   = isolate_q;
   assign sub_rst_no  = sub_rst_nq;
   assign guard_ena_o = guard_ena_q;
   assign irq_clr_o   = irq_clr_q;
   assign busy_o      = busy_q;
   assign forced_o    = forced_q;
   assign fail_o      = fail_q;
   assign recov_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: doc/guard_recovery_ctrl.md
Name: guard_recovery_ctrl

Overview:
- Sequences recovery of a subordinate protected by the slave guard.
- On a guard reset request it isolates the subordinate's AXI port, drains or abandons outstanding traffic, pulses the subordinate reset, clears the guard's sticky error and re-enables the path.
- Sits between slv_guard_top (irq/rst_req/guard_ena), an axi_isolate instance on the subordinate side, and the subordinate's reset input.

Parameters:
- IsoTimeout, 1024, max cycles to wait for isolation to complete before forcing reset.
- RstHoldCycles, 16, cycles sub_rst_no is held low (≥1).
- SettleCycles, 8, cycles waited after reset release before resuming traffic (≥1).
- MaxRecov, 3, recoveries allowed before entering FAILED (≥1).
- TmrWidth, $clog2(max(IsoTimeout,RstHoldCycles,SettleCycles)+1), internal timer width; do not override.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset, asynchronous, active-low.
- enable_i, in, 1, recovery enable; when 0 rst_req_i is ignored in IDLE.
- rst_req_i, in, 1, level reset request from guard.
- isolated_i, in, 1, isolator reports port isolated with no outstanding transactions.
- sw_clear_i, in, 1, software pulse: leave FAILED, clear recovery counter.
- isolate_o, out, 1, request isolation of subordinate port.
- sub_rst_no, out, 1, active-low reset to subordinate.
- guard_ena_o, out, 1, guard enable.
- irq_clr_o, out, 1, one-cycle pulse clearing guard irq/rst_req state.
- busy_o, out, 1, high in any state other than IDLE.
- forced_o, out, 1, sticky: last isolation timed out; cleared on next trigger.
- fail_o, out, 1, high in FAILED.
- recov_cnt_o, out, 8, completed recoveries, saturating at 255.

Behaviour:
- All outputs are registered. Reset values:
  - isolate_o=0, sub_rst_no=1, guard_ena_o=1, irq_clr_o=0, busy_o=0, forced_o=0, fail_o=0, recov_cnt_o=0.
  - State IDLE, timer 0.
- States and transitions:
  - IDLE: enable_i&rst_req_i sampled high → ISOLATE. Next cycle isolate_o=1, guard_ena_o=1, busy_o=1, forced_o=0, timer=0.
  - ISOLATE:
    - isolated_i=1 → RESET.
    - Else if timer==IsoTimeout-1 → RESET with forced_o=1.
    - Else timer++.
    - isolated_i and timeout in the same cycle: not forced.
  - RESET:
    - On entry sub_rst_no=0, guard_ena_o=0, timer=0.
    - Stays exactly RstHoldCycles cycles, then → SETTLE.
  - SETTLE:
    - sub_rst_no=1. Stays SettleCycles cycles.
    - On the last cycle, irq_clr_o pulses for exactly one cycle and guard_ena_o returns to 1 the following cycle.
    - Increment recov_cnt_o (saturating).
    - If the incremented count ≥ MaxRecov → FAILED, else → RESUME.
  - RESUME:
    - isolate_o=0.
    - Wait for isolated_i=0 → IDLE, busy_o=0.
    - No timeout.
  - FAILED:
    - isolate_o=1, guard_ena_o=1, sub_rst_no=1, fail_o=1.
    - sw_clear_i → RESUME, recov_cnt_o=0, fail_o=0.
- Latency:
  - Minimum trigger-to-reset-assert is 2 cycles: IDLE→ISOLATE, then isolated_i already high.
  - Reset pulse width is exactly RstHoldCycles.
- rst_req_i still high on return to IDLE retriggers immediately. irq_clr_o is expected to drop it; no lockout.
- Edge cases:
  - sw_clear_i outside FAILED: clears recov_cnt_o only.
  - enable_i deassert mid-sequence: no effect. A started sequence always completes.
  - rst_req_i deasserting mid-sequence: no effect.
- Asynchronous reset mid-sequence: all outputs return to reset values immediately, including sub_rst_no=1 and isolate_o=0.

Test Plan:
- Reset, enable_i=1, rst_req_i high 1 cycle, isolated_i high 3 cycles after isolate_o → sub_rst_no low exactly 16 cycles, then after 8 cycles irq_clr_o pulses once, recov_cnt_o=1, isolate_o drops, busy_o=0 after isolated_i falls.
- isolated_i held 0 → sub_rst_no falls exactly 1024 cycles after isolate_o rises, forced_o=1; next trigger clears forced_o.
- Three consecutive recoveries (MaxRecov=3) → after third SETTLE fail_o=1, isolate_o stays 1; sw_clear_i pulse → fail_o=0, recov_cnt_o=0, return to IDLE.
- enable_i=0 with rst_req_i=1 → no state change, all outputs at reset values for 100 cycles.
- Assert rst_ni low during RESET phase → sub_rst_no=1, isolate_o=0, busy_o=0 same cycle; after release no sequence until new request.
- isolated_i and timeout coincide at cycle IsoTimeout-1 → forced_o remains 0.
